immediate_gen_pipe: RTL and testbench

//  Pipelined, parametrised immediate generator for the datapath decode stage.
//  - Extracts and extends the immediate field of formats a/b/c.
//  - Adds format d (PREFIX), which supplies the upper 16 bits of a full 32-bit

---
 rtl/immediate_gen_pipe.sv | 238 +++++++++++++++++++++++
 tb/tb_immediate_gen_pipe.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/immediate_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : immediate_gen_pipe
// Description : Two-stage pipelined immediate generator for the decode stage.
//               Extracts and extends the immediate field of formats a/b/c and
//               supports a PREFIX format (d) that supplies the upper 16 bits
//               of a full 32-bit immediate to the next format-b instruction.
//               Valid/ready handshake on both sides.
// Ports       : clk, rst (sync, active-high), flush
//               in_valid/in_ready, IR[31:0], InstructionFormat[1:0], Extend[1:0]
//               out_valid/out_ready, ImmediateBlock_Out[DATA_W-1:0],
//               out_prefixed, illegal_imm
// Parameters  : DATA_W   output width (>= 32), upper bits extended from bit 31
//               FLUSH_EN 1: flush honoured, 0: flush ignored
// Options     : IMMGEN_ILLEGAL_CHK_EN - enables the illegal-immediate checker;
//               when undefined illegal_imm is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module immediate_gen_pipe #(
    parameter int DATA_W   = 32,
    parameter int FLUSH_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       IR,
    input  logic [1:0]        InstructionFormat,
    input  logic [1:0]        Extend,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ImmediateBlock_Out,
    output logic              out_prefixed,
    output logic              illegal_imm
);

    localparam logic [1:0] FMT_A     = 2'd0;
    localparam logic [1:0] FMT_B     = 2'd1;
    localparam logic [1:0] FMT_C     = 2'd2;
    localparam logic [1:0] FMT_D     = 2'd3;
    localparam logic [1:0] EXT_ZERO  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        PREFIXED = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [15:0]        prefix_reg;

    logic               flush_eff;
    logic               accept;
    logic               s1_adv;
    logic               s1_load;
    logic               prefix_hit;

    logic               s1_valid;
    logic [1:0]         s1_fmt;
    logic [1:0]         s1_ext;
    logic [25:0]        s1_field;
    logic               s1_prefixed;
    logic [15:0]        s1_hi;

    logic               s2_valid;
    logic [DATA_W-1:0]  s2_data;
    logic               s2_prefixed;

    logic [31:0]        low;
    logic               fill;
    logic [DATA_W-1:0]  ext_full;

    // IR[5:0] carries no immediate bits in any format.
    logic               unused_ir_low;
    assign unused_ir_low = &{1'b1, IR[5:0]};

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    assign flush_eff  = flush & (FLUSH_EN != 0);
    assign s1_adv     = !s2_valid | out_ready;
    assign s1_load    = !s1_valid | s1_adv;
    assign in_ready   = !rst & !flush_eff & s1_load;
    assign accept     = in_valid & in_ready;
    assign prefix_hit = (state == PREFIXED) && (InstructionFormat == FMT_B);

    // ------------------------------------------------------------------------
    // Prefix FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prefix_reg <= '0;
        end else begin
            state <= state_next;
            if (accept && (InstructionFormat == FMT_D)) begin
                prefix_reg <= IR[21:6];
            end
        end
    end

    // Any accepted non-prefix word consumes (or orphans) a pending prefix.
    always_comb begin
        state_next = state;
        if (flush_eff) begin
            state_next = IDLE;
        end else if (accept) begin
            if (InstructionFormat == FMT_D) begin
                state_next = PREFIXED;
            end else begin
                state_next = IDLE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: decoded fields. A prefix word leaves a bubble.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_fmt      <= FMT_A;
            s1_ext      <= 2'd0;
            s1_field    <= '0;
            s1_prefixed <= 1'b0;
            s1_hi       <= '0;
        end else if (flush_eff) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= accept && (InstructionFormat != FMT_D);
            if (accept) begin
                s1_fmt      <= InstructionFormat;
                s1_ext      <= Extend;
                s1_field    <= IR[31:6];
                s1_prefixed <= prefix_hit;
                s1_hi       <= prefix_reg;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Extension. s1_field[15:0] is IR[21:6], s1_field is IR[31:6].
    // Extend==3 behaves as sign extension.
    // ------------------------------------------------------------------------
    always_comb begin
        low  = '0;
        fill = 1'b0;
        case (s1_fmt)
            FMT_B: begin
                if (s1_prefixed) begin
                    low = {s1_hi, s1_field[15:0]};
                end else begin
                    case (s1_ext)
                        EXT_ZERO:  low = {16'b0, s1_field[15:0]};
                        EXT_UPPER: low = {s1_field[15:0], 16'b0};
                        default:   low = {{16{s1_field[15]}}, s1_field[15:0]};
                    endcase
                end
            end
            FMT_C: begin
                case (s1_ext)
                    EXT_ZERO:  low = {6'b0, s1_field};
                    EXT_UPPER: low = {s1_field, 6'b0};
                    default:   low = {{6{s1_field[25]}}, s1_field};
                endcase
            end
            default: low = '0;
        endcase
        fill = (s1_prefixed || (s1_ext != EXT_ZERO)) ? low[31] : 1'b0;
        ext_full       = '0;
        ext_full[31:0] = low;
        for (int i = 32; i < DATA_W; i++) begin
            ext_full[i] = fill;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: extended result, held until the consumer takes it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            s2_data     <= '0;
            s2_prefixed <= 1'b0;
        end else if (flush_eff) begin
            s2_valid <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data     <= ext_full;
                s2_prefixed <= s1_prefixed;
            end
        end
    end

    assign out_valid          = s2_valid;
    assign ImmediateBlock_Out = s2_data;
    assign out_prefixed       = s2_prefixed;

    // ------------------------------------------------------------------------
    // Illegal-immediate checker
    // ------------------------------------------------------------------------
`ifdef IMMGEN_ILLEGAL_CHK_EN
    logic in_illegal;
    logic s1_illegal;
    logic s2_illegal;

    // Reserved Extend on b/c (ignored for a prefixed b), or an a/c that
    // discards a pending prefix.
    assign in_illegal =
        ((Extend == 2'd3) &&
         (((InstructionFormat == FMT_B) && !prefix_hit) || (InstructionFormat == FMT_C))) ||
        ((state == PREFIXED) &&
         ((InstructionFormat == FMT_A) || (InstructionFormat == FMT_C)));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_illegal <= 1'b0;
            s2_illegal <= 1'b0;
        end else if (!flush_eff) begin
            if (s1_load && accept) begin
                s1_illegal <= in_illegal;
            end
            if (s1_adv && s1_valid) begin
                s2_illegal <= s1_illegal;
            end
        end
    end

    assign illegal_imm = s2_illegal;
`else
    assign illegal_imm = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_immediate_gen_pipe.sv
`default_nettype none
module tb_immediate_gen_pipe;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic          out_prefixed, illegal_imm;
    logic [31:0]   IR;
    logic [1:0]    fmt, ext;
    logic [DW-1:0] dout;

    int tests = 0;
    int fails = 0;
    int out_count = 0;

    always #5 clk = ~clk;

    immediate_gen_pipe #(.DATA_W(DW), .FLUSH_EN(1)) dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .IR                 (IR),
        .InstructionFormat  (fmt),
        .Extend             (ext),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .ImmediateBlock_Out (dout),
        .out_prefixed       (out_prefixed),
        .illegal_imm        (illegal_imm)
    );

    typedef struct {
        logic [31:0] data;
        logic        pref;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [1:0]  f;
        logic [1:0]  e;
        logic [25:0] field;
        logic [31:0] exp;
    } vec_t;

    exp_t        q[$];
    bit          m_pref = 1'b0;
    logic [15:0] m_pref_val = '0;
    bit          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Reference model: plain arithmetic on the extracted fields.
    function automatic exp_t model_entry(input logic [31:0] ir, input logic [1:0] f,
                                         input logic [1:0] e);
        longint v, f16, f26;
        exp_t   r;
        f16 = longint'((ir >> 6) & 32'h0000FFFF);
        f26 = longint'((ir >> 6) & 32'h03FFFFFF);
        v = 0;
        r.pref = 1'b0;
        r.ill  = 1'b0;
        if (f == 2'd1 && m_pref) begin
            v = longint'(m_pref_val) * 65536 + f16;
            r.pref = 1'b1;
        end else if (f == 2'd1) begin
            case (e)
                2'd1:    v = f16;
                2'd2:    v = f16 * 65536;
                default: v = (f16 >= 32768) ? f16 - 65536 : f16;
            endcase
        end else if (f == 2'd2) begin
            case (e)
                2'd1:    v = f26;
                2'd2:    v = f26 * 64;
                default: v = (f26 >= 33554432) ? f26 - 67108864 : f26;
            endcase
        end
        r.data = v[31:0];
`ifdef IMMGEN_ILLEGAL_CHK_EN
        r.ill = (m_pref && (f == 2'd0 || f == 2'd2)) ||
                (e == 2'd3 && (f == 2'd2 || (f == 2'd1 && !m_pref)));
`endif
        return r;
    endfunction

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_in_ready", in_ready, 0);
            q.delete();
            m_pref = 1'b0;
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", dout, hold_d);
            end
            hold_v = out_valid && !out_ready && !flush;
            hold_d = dout;
            if (out_valid && out_ready) begin
                out_count++;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_out: got %0h, required no output", dout);
                end else begin
                    e = q.pop_front();
                    chk("out_data", dout, e.data);
                    chk("out_pref", out_prefixed, e.pref);
                    chk("out_ill", illegal_imm, e.ill);
                end
            end
            if (flush) begin
                chk("flush_in_ready", in_ready, 0);
                q.delete();
                m_pref = 1'b0;
            end else if (in_valid && in_ready) begin
                if (fmt == 2'd3) begin
                    m_pref     = 1'b1;
                    m_pref_val = IR[21:6];
                end else begin
                    q.push_back(model_entry(IR, fmt, ext));
                    m_pref = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ir, input logic [1:0] f, input logic [1:0] e);
        int n;
        n = 0;
        in_valid = 1'b1;
        IR  = ir;
        fmt = f;
        ext = e;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: in_ready 0, required 1");
                break;
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input logic [31:0] d, input logic p, input logic il, input string nm);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 50) begin
                tests++;
                fails++;
                $display("FAIL %s_timeout: out_valid 0, required 1", nm);
                return;
            end
        end
        chk({nm, "_data"}, dout, d);
        chk({nm, "_pref"}, out_prefixed, p);
        chk({nm, "_ill"}, illegal_imm, il);
        tick();
    endtask

    function automatic logic [31:0] mk_b(input logic [15:0] f16);
        return {10'h3FF, f16, 6'h3F};
    endfunction

    vec_t vec[11];
    bit   rnd_on;

    initial begin
        int          cnt0;
        logic [31:0] ir;
        logic        exp_ill;

        vec[0]  = '{2'd1, 2'd0, 26'h0008001, 32'hFFFF8001};
        vec[1]  = '{2'd1, 2'd1, 26'h0008001, 32'h00008001};
        vec[2]  = '{2'd1, 2'd2, 26'h0008001, 32'h80010000};
        vec[3]  = '{2'd1, 2'd3, 26'h0008001, 32'hFFFF8001};
        vec[4]  = '{2'd1, 2'd0, 26'h0007FFF, 32'h00007FFF};
        vec[5]  = '{2'd2, 2'd0, 26'h2000001, 32'hFE000001};
        vec[6]  = '{2'd2, 2'd1, 26'h2000001, 32'h02000001};
        vec[7]  = '{2'd2, 2'd2, 26'h2000001, 32'h80000040};
        vec[8]  = '{2'd0, 2'd0, 26'h3FFFFFF, 32'h00000000};
        vec[9]  = '{2'd0, 2'd2, 26'h3FFFFFF, 32'h00000000};
        vec[10] = '{2'd2, 2'd0, 26'h1234567, 32'h01234567};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        IR = '0; fmt = 2'd0; ext = 2'd0; rnd_on = 1'b0;

        // Reset held two cycles, then released.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", dout, 0);
        chk("rst_out_pref", out_prefixed, 0);
        chk("rst_illegal", illegal_imm, 0);
        chk("rst_release_in_ready", in_ready, 1);
        tick();

        // Single-word vectors with latency check.
        foreach (vec[i]) begin
            if (vec[i].f == 2'd2)      ir = {vec[i].field, 6'h3F};
            else if (vec[i].f == 2'd1) ir = mk_b(vec[i].field[15:0]);
            else                       ir = 32'hFFFFFFFF;
            exp_ill = 1'b0;
`ifdef IMMGEN_ILLEGAL_CHK_EN
            exp_ill = (vec[i].f != 2'd0) && (vec[i].e == 2'd3);
`endif
            send(ir, vec[i].f, vec[i].e);
            @(negedge clk);
            chk($sformatf("vec%0d_early", i), out_valid, 0);
            tick();
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_data", i), dout, vec[i].exp);
            chk($sformatf("vec%0d_pref", i), out_prefixed, 0);
            chk($sformatf("vec%0d_ill", i), illegal_imm, exp_ill);
            tick();
        end

        // Prefix pair: exactly one output.
        cnt0 = out_count;
        send(mk_b(16'hDEAD), 2'd3, 2'd0);
        send(mk_b(16'hBEEF), 2'd1, 2'd1);
        wait_out(32'hDEADBEEF, 1'b1, 1'b0, "prefix");
        repeat (5) tick();
        chk("prefix_count", out_count - cnt0, 1);

        // Back-pressure: 8 words, out_ready low for 5 cycles.
        out_ready = 1'b0;
        cnt0 = out_count;
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    send({26'($urandom), 6'h00}, 2'd2, 2'($urandom_range(0, 2)));
                    if (k == 1) begin
                        @(negedge clk);
                        chk("bp_in_ready", in_ready, 0);
                        tick();
                    end
                end
            end
        join
        repeat (10) tick();
        chk("bp_count", out_count - cnt0, 8);
        chk("bp_queue_empty", q.size(), 0);

        // Prefix, flush, then a plain b.
        send(mk_b(16'h1234), 2'd3, 2'd0);
        flush = 1'b1;
        in_valid = 1'b1;
        IR = mk_b(16'h5555); fmt = 2'd1; ext = 2'd0;
        @(negedge clk);
        chk("flush_cycle_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        send(mk_b(16'h0001), 2'd1, 2'd0);
        wait_out(32'h00000001, 1'b0, 1'b0, "post_flush");

        // Flush with entries held under back-pressure: nothing emerges.
        out_ready = 1'b0;
        send({26'h0000123, 6'h0}, 2'd2, 2'd0);
        send({26'h0000456, 6'h0}, 2'd2, 2'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        cnt0 = out_count;
        repeat (6) tick();
        chk("flush_drop_count", out_count - cnt0, 0);

        // Reset mid-operation: in-flight entries lost.
        out_ready = 1'b0;
        send({26'h0000777, 6'h0}, 2'd2, 2'd1);
        send(mk_b(16'hAAAA), 2'd3, 2'd0);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        out_ready = 1'b1;
        cnt0 = out_count;
        repeat (6) tick();
        chk("rst_drop_count", out_count - cnt0, 0);
        send(mk_b(16'h00F0), 2'd1, 2'd0);
        wait_out(32'h000000F0, 1'b0, 1'b0, "post_rst");

        // Orphaned prefix followed by fmt c.
        exp_ill = 1'b0;
`ifdef IMMGEN_ILLEGAL_CHK_EN
        exp_ill = 1'b1;
`endif
        send(mk_b(16'h4321), 2'd3, 2'd0);
        send({26'h0000055, 6'h3F}, 2'd2, 2'd0);
        wait_out(32'h00000055, 1'b0, exp_ill, "orphan");

        // Randomized traffic against the model.
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int n = 0; n < 400; n++) begin
                    int r;
                    r = $urandom_range(0, 19);
                    if (r == 0) begin
                        flush = 1'b1;
                        tick();
                        flush = 1'b0;
                    end else if (r < 4) begin
                        tick();
                    end else begin
                        send($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
                    end
                end
                rnd_on = 1'b0;
            end
        join
        out_ready = 1'b1;
        repeat (20) tick();
        chk("final_queue_empty", q.size(), 0);
        chk("final_out_valid", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
